// File: rtl/rate_gate_controller.sv
// rate_gate_controller
// Sequences gated pulse-rate measurement windows over NUM_CH asynchronous
// pulse inputs. Supports single-shot or back-to-back windows of programmable
// length. Each finished window is latched into Rates/Saturated and offered to
// the register side with a valid/ack handshake. A sticky Overrun flag reports
// a result that was overwritten before it was acknowledged.
module rate_gate_controller #(
    parameter int          NUM_CH   = 4,
    parameter int          CNT_W    = 32,
    parameter int          GATE_W   = 32,
    parameter int unsigned DEF_GATE = 50000000
) (
    input  logic                    Clk,
    input  logic                    nRst,
    input  logic                    Start,
    input  logic                    Stop,
    input  logic                    Continuous,
    input  logic [GATE_W-1:0]       GateLen,
    input  logic [NUM_CH-1:0]       PulseIn,
    output logic [NUM_CH*CNT_W-1:0] Rates,
    output logic [NUM_CH-1:0]       Saturated,
    output logic                    ResultValid,
    input  logic                    ResultAck,
    output logic                    Overrun,
    output logic                    Busy,
    output logic [15:0]             WindowCount
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_COUNT = 2'd2;
    localparam logic [1:0] ST_LATCH = 2'd3;

    localparam logic [GATE_W-1:0] DEF_GATE_V = GATE_W'(DEF_GATE);

    logic [1:0]        state;
    logic [1:0]        next_state;
    logic              cont_reg;
    logic [GATE_W-1:0] gate_reg;
    logic [GATE_W-1:0] gate_cnt;
    logic [GATE_W-1:0] gate_len_eff;

    // Three-stage synchronizer; stage 1 may go metastable, stages 2/3 are
    // clean and their difference gives a one-cycle rising-edge strobe.
    logic [NUM_CH-1:0] sync1;
    logic [NUM_CH-1:0] sync2;
    logic [NUM_CH-1:0] sync3;
    logic [NUM_CH-1:0] rise;

    logic [CNT_W-1:0]  cnt [NUM_CH];
    logic [NUM_CH-1:0] sat;

    logic              start_accept;
    logic              latch_fire;
    logic              gate_done;

    // A zero gate length selects the default one-second window.
    assign gate_len_eff = (GateLen == '0) ? DEF_GATE_V : GateLen;
    assign rise         = sync2 & ~sync3;
    assign start_accept = (state == ST_IDLE) && Start && !Stop;
    assign latch_fire   = (state == ST_LATCH) && !Stop;
    // gate_reg is never zero, so the terminal count cannot underflow.
    assign gate_done    = (gate_cnt == gate_reg - GATE_W'(1));

    // Synchronize the asynchronous pulse inputs into the clock domain.
    always_ff @(posedge Clk or negedge nRst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!nRst) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= PulseIn;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // Next-state selection; Stop overrides everything and returns to IDLE.
    always_comb begin
        // NOTE: the default assignment first keeps this block free of
        // inferred latches on paths that do not change state.
        next_state = state;
        if (Stop) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (Start) next_state = ST_LOAD;
                ST_LOAD:  next_state = ST_COUNT;
                ST_COUNT: if (gate_done) next_state = ST_LATCH;
                ST_LATCH: next_state = cont_reg ? ST_COUNT : ST_IDLE;
                default:  next_state = ST_IDLE;
            endcase
        end
    end

    // State register, Busy flag, window mode and gate timer.
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            state    <= ST_IDLE;
            Busy     <= 1'b0;
            cont_reg <= 1'b0;
            gate_reg <= DEF_GATE_V;
            gate_cnt <= '0;
        end else begin
            state <= next_state;
            Busy  <= (next_state != ST_IDLE);
            if (start_accept) begin
                cont_reg <= Continuous;
            end
            if (!Stop) begin
                case (state)
                    ST_LOAD: begin
                        gate_reg <= gate_len_eff;
                        gate_cnt <= '0;
                    end
                    ST_COUNT: begin
                        gate_cnt <= gate_cnt + GATE_W'(1);
                    end
                    ST_LATCH: begin
                        gate_reg <= gate_len_eff;
                        gate_cnt <= '0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Per-channel saturating edge counters; cleared at LOAD and LATCH so
    // rises arriving during the LATCH cycle are dropped.
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            // NOTE: the counter array is a handful of flops, not a RAM, so it
            // is given a reset like any other state to come up at zero.
            for (int k = 0; k < NUM_CH; k++) begin
                cnt[k] <= '0;
            end
            sat <= '0;
        end else if (state == ST_LOAD || state == ST_LATCH) begin
            for (int k = 0; k < NUM_CH; k++) begin
                cnt[k] <= '0;
            end
            sat <= '0;
        end else if (state == ST_COUNT) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (rise[k]) begin
                    if (&cnt[k]) begin
                        sat[k] <= 1'b1;
                    end else begin
                        cnt[k] <= cnt[k] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Result latch, valid/ack handshake, sticky overrun and window counter.
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            Rates       <= '0;
            Saturated   <= '0;
            ResultValid <= 1'b0;
            Overrun     <= 1'b0;
            WindowCount <= '0;
        end else begin
            if (start_accept) begin
                Overrun <= 1'b0;
            end
            if (latch_fire) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    Rates[k*CNT_W +: CNT_W] <= cnt[k];
                end
                Saturated   <= sat;
                ResultValid <= 1'b1;
                WindowCount <= WindowCount + 16'd1;
                // An ack in the same cycle consumes the old result in time.
                if (ResultValid && !ResultAck) begin
                    Overrun <= 1'b1;
                end
            end else if (ResultAck) begin
                ResultValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rate_gate_controller.sv
// tb_rate_gate_controller
// Directed sequences, a vector table and randomized traffic for
// rate_gate_controller, compared every cycle against a window-position model.
module tb_rate_gate_controller;

    localparam int NCH     = 4;
    localparam int CW      = 4;
    localparam int GW      = 16;
    localparam int DEFG    = 64;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic            Clk = 1'b0;
    logic            nRst;
    logic            Start;
    logic            Stop;
    logic            Continuous;
    logic [GW-1:0]   GateLen;
    logic [NCH-1:0]  PulseIn;
    logic [NCH*CW-1:0] Rates;
    logic [NCH-1:0]  Saturated;
    logic            ResultValid;
    logic            ResultAck;
    logic            Overrun;
    logic            Busy;
    logic [15:0]     WindowCount;

    int checks = 0;
    int errors = 0;

    rate_gate_controller #(
        .NUM_CH  (NCH),
        .CNT_W   (CW),
        .GATE_W  (GW),
        .DEF_GATE(DEFG)
    ) dut (
        .Clk        (Clk),
        .nRst       (nRst),
        .Start      (Start),
        .Stop       (Stop),
        .Continuous (Continuous),
        .GateLen    (GateLen),
        .PulseIn    (PulseIn),
        .Rates      (Rates),
        .Saturated  (Saturated),
        .ResultValid(ResultValid),
        .ResultAck  (ResultAck),
        .Overrun    (Overrun),
        .Busy       (Busy),
        .WindowCount(WindowCount)
    );

    always #5 Clk = ~Clk;

    // ---------------- reference model ----------------
    // The window is tracked as a position: -1 = setup cycle, 0..G-1 = counting
    // cycles, G = latch cycle. Pulse history gives the synchronizer delay.
    bit          m_active;
    bit          m_cont;
    int          m_pos;
    int          m_greg;
    int          m_cnt   [NCH];
    bit [NCH-1:0] m_sat;
    int          m_rates [NCH];
    bit [NCH-1:0] m_rsat;
    bit          m_valid;
    bit          m_over;
    int          m_wc;
    bit [NCH-1:0] hist [3];

    function automatic int eff_gate(input int g);
        return (g == 0) ? DEFG : g;
    endfunction

    task automatic model_reset();
        m_active = 0; m_cont = 0; m_pos = 0; m_greg = DEFG;
        for (int k = 0; k < NCH; k++) begin
            m_cnt[k] = 0;
            m_rates[k] = 0;
        end
        m_sat = '0; m_rsat = '0; m_valid = 0; m_over = 0; m_wc = 0;
        for (int i = 0; i < 3; i++) hist[i] = '0;
    endtask

    task automatic model_step();
        bit [NCH-1:0] rise;
        bit           latched;
        rise    = hist[1] & ~hist[2];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = PulseIn;
        latched = 0;
        if (Stop) begin
            m_active = 0;
        end else if (!m_active) begin
            if (Start) begin
                m_active = 1; m_pos = -1; m_cont = Continuous; m_over = 0;
            end
        end else if (m_pos < 0) begin
            m_greg = eff_gate(int'(GateLen));
            m_pos  = 0;
            for (int k = 0; k < NCH; k++) m_cnt[k] = 0;
            m_sat = '0;
        end else if (m_pos < m_greg) begin
            for (int k = 0; k < NCH; k++) begin
                if (rise[k]) begin
                    if (m_cnt[k] == CNT_MAX) m_sat[k] = 1;
                    else m_cnt[k] = m_cnt[k] + 1;
                end
            end
            m_pos = m_pos + 1;
        end else begin
            latched = 1;
            for (int k = 0; k < NCH; k++) begin
                m_rates[k] = m_cnt[k];
                m_cnt[k] = 0;
            end
            m_rsat = m_sat;
            m_sat  = '0;
            m_wc   = (m_wc + 1) % 65536;
            m_greg = eff_gate(int'(GateLen));
            m_pos  = 0;
            if (!m_cont) m_active = 0;
        end
        if (latched) begin
            if (m_valid && !ResultAck) m_over = 1;
            m_valid = 1;
        end else if (ResultAck) begin
            m_valid = 0;
        end
    endtask

    function automatic logic [NCH*CW-1:0] model_rates();
        logic [NCH*CW-1:0] r;
        for (int k = 0; k < NCH; k++) r[k*CW +: CW] = CW'(m_rates[k]);
        return r;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock edge: DUT and model advance together, outputs compared at negedge.
    task automatic step();
        @(posedge Clk);
        model_step();
        @(negedge Clk);
        check("m_rates",  32'(Rates),       32'(model_rates()));
        check("m_sat",    32'(Saturated),   32'(m_rsat));
        check("m_valid",  32'(ResultValid), 32'(m_valid));
        check("m_over",   32'(Overrun),     32'(m_over));
        check("m_busy",   32'(Busy),        32'(m_active));
        check("m_wcount", 32'(WindowCount), 32'(m_wc));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rates"},  32'(Rates),       32'h0);
        check({tag, "_sat"},    32'(Saturated),   32'h0);
        check({tag, "_valid"},  32'(ResultValid), 32'h0);
        check({tag, "_over"},   32'(Overrun),     32'h0);
        check({tag, "_busy"},   32'(Busy),        32'h0);
        check({tag, "_wcount"}, 32'(WindowCount), 32'h0);
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic mid_reset();
        #2 nRst = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge Clk);
        nRst = 1'b1;
    endtask

    task automatic ack_cycle();
        ResultAck = 1'b1;
        step();
        ResultAck = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic          start;
        logic          stop;
        logic          cont;
        logic [GW-1:0] glen;
        logic [NCH-1:0] pulse;
        logic          ack;
        logic          exp_valid;
        logic          exp_busy;
        logic [NCH*CW-1:0] exp_rates;
        logic [15:0]   exp_wc;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic sp, input logic ct,
                                input logic [GW-1:0] gl, input logic [NCH-1:0] pl,
                                input logic ak, input logic ev, input logic eb,
                                input logic [NCH*CW-1:0] er, input logic [15:0] ew);
        vec_t v;
        v.start = st; v.stop = sp; v.cont = ct; v.glen = gl; v.pulse = pl;
        v.ack = ak; v.exp_valid = ev; v.exp_busy = eb; v.exp_rates = er; v.exp_wc = ew;
        return v;
    endfunction

    vec_t tbl [14];

    initial begin
        // Table precondition: IDLE, no pending result, Rates=16'h0100, 1 window.
        tbl[0]  = mk(1, 1, 0, 2, 4'h0, 0, 0, 0, 16'h0100, 1); // Stop beats Start
        tbl[1]  = mk(0, 0, 0, 2, 4'h0, 1, 0, 0, 16'h0100, 1); // ack with nothing valid
        tbl[2]  = mk(1, 0, 0, 2, 4'h1, 0, 0, 1, 16'h0100, 1); // start, LOAD
        tbl[3]  = mk(1, 0, 0, 2, 4'h0, 0, 0, 1, 16'h0100, 1); // start ignored
        tbl[4]  = mk(0, 0, 0, 2, 4'h2, 0, 0, 1, 16'h0100, 1); // ch1 rise lands in LATCH
        tbl[5]  = mk(0, 0, 0, 2, 4'h0, 0, 0, 1, 16'h0100, 1);
        tbl[6]  = mk(0, 0, 0, 2, 4'h0, 0, 1, 0, 16'h0001, 2); // latch, ch1 dropped
        tbl[7]  = mk(0, 0, 0, 2, 4'h0, 1, 0, 0, 16'h0001, 2);
        tbl[8]  = mk(1, 0, 1, 1, 4'h0, 0, 0, 1, 16'h0001, 2); // continuous, 1-cycle gate
        tbl[9]  = mk(0, 0, 1, 1, 4'h0, 0, 0, 1, 16'h0001, 2);
        tbl[10] = mk(0, 0, 1, 1, 4'h0, 0, 0, 1, 16'h0001, 2);
        tbl[11] = mk(0, 0, 1, 1, 4'h0, 0, 1, 1, 16'h0000, 3);
        tbl[12] = mk(0, 0, 1, 1, 4'h0, 1, 0, 1, 16'h0000, 3);
        tbl[13] = mk(0, 1, 1, 1, 4'h0, 0, 0, 0, 16'h0000, 3); // Stop in LATCH: no latch

        nRst = 1'b0; Start = 0; Stop = 0; Continuous = 0; GateLen = '0;
        PulseIn = '0; ResultAck = 0;
        model_reset();
        repeat (2) @(negedge Clk);
        check_all_zero("reset");
        nRst = 1'b1;

        // ---- single shot, GateLen=100: result at edge G+2 ----
        GateLen = 16'd100; Continuous = 0; Start = 1;
        step();
        Start = 0;
        check("t1_busy_after_start", 32'(Busy), 32'h1);
        for (int e = 1; e <= 102; e++) begin
            PulseIn[0] = (e >= 10 && e < 90 && ((e - 10) % 8) < 4);
            PulseIn[1] = (e >= 30 && e < 90 && ((e - 30) % 20) < 3);
            step();
            if (e == 101) check("t1_valid_early", 32'(ResultValid), 32'h0);
        end
        PulseIn = '0;
        check("t1_valid", 32'(ResultValid), 32'h1);
        check("t1_rates", 32'(Rates), 32'h003A);
        check("t1_sat",   32'(Saturated), 32'h0);
        check("t1_busy",  32'(Busy), 32'h0);
        check("t1_wc",    32'(WindowCount), 32'd1);
        ack_cycle();
        check("t1_ack_clears", 32'(ResultValid), 32'h0);

        // ---- continuous, GateLen=50: period 51, ack coincident with latch ----
        GateLen = 16'd50; Continuous = 1; Start = 1;
        step();
        Start = 0;
        for (int e = 1; e <= 154; e++) begin
            PulseIn   = (e % 51 == 20) ? 4'b0100 : 4'b0000;
            ResultAck = (e == 53) || (e == 154);
            step();
            if (e == 51 || e == 102) check("t2_valid_gap", 32'(ResultValid), 32'h0);
            if (e == 52 || e == 103 || e == 154) begin
                check("t2_valid", 32'(ResultValid), 32'h1);
                check("t2_rates", 32'(Rates), 32'h0100);
                check("t2_over",  32'(Overrun), 32'h0);
            end
        end
        PulseIn = '0; Stop = 1; ResultAck = 1;
        step();
        Stop = 0; ResultAck = 0;
        check("t2_stop_busy", 32'(Busy), 32'h0);

        // ---- continuous without ack: overrun after second latch ----
        GateLen = 16'd50; Continuous = 1; Start = 1;
        step();
        Start = 0;
        for (int e = 1; e <= 103; e++) begin
            PulseIn = (e == 10 || e == 20 || e == 60 || e == 70 ||
                       e == 80 || e == 90 || e == 95) ? 4'b0001 : 4'b0000;
            step();
            if (e == 52) begin
                check("t3_w1_rates", 32'(Rates), 32'h0002);
                check("t3_w1_over",  32'(Overrun), 32'h0);
            end
        end
        PulseIn = '0;
        check("t3_w2_rates", 32'(Rates), 32'h0005);
        check("t3_over",     32'(Overrun), 32'h1);
        Stop = 1; ResultAck = 1;
        step();
        Stop = 0; ResultAck = 0;
        check("t3_over_sticky", 32'(Overrun), 32'h1);
        // Restart with a one-cycle gate; the accepted Start clears Overrun.
        GateLen = 16'd1; Continuous = 0; Start = 1; PulseIn = 4'b1000;
        step();
        Start = 0; PulseIn = '0;
        check("t3_over_cleared", 32'(Overrun), 32'h0);
        step();
        step();
        check("t3_g1_valid_early", 32'(ResultValid), 32'h0);
        step();
        check("t3_g1_valid", 32'(ResultValid), 32'h1);
        check("t3_g1_rates", 32'(Rates), 32'h1000);
        check("t3_g1_busy",  32'(Busy), 32'h0);
        ack_cycle();

        // ---- stop mid-window ----
        GateLen = 16'd100; Continuous = 0; Start = 1;
        step();
        Start = 0;
        for (int e = 1; e <= 20; e++) begin
            PulseIn[0] = ((e % 4) < 2);
            Stop = (e == 20);
            step();
        end
        Stop = 0; PulseIn = '0;
        check("t4_busy",  32'(Busy), 32'h0);
        check("t4_valid", 32'(ResultValid), 32'h0);
        check("t4_rates", 32'(Rates), 32'h1000);
        check("t4_wc",    32'(WindowCount), 32'd7);
        repeat (110) step();
        check("t4_valid_later", 32'(ResultValid), 32'h0);

        // ---- saturation: 20 pulses ch0, exactly 15 on ch1 ----
        GateLen = 16'd200; Continuous = 0; Start = 1;
        step();
        Start = 0;
        for (int e = 1; e <= 202; e++) begin
            PulseIn[0] = (e >= 10 && e < 90 && ((e - 10) % 4) < 2);
            PulseIn[1] = (e >= 10 && e < 70 && ((e - 10) % 4) < 2);
            step();
        end
        PulseIn = '0;
        check("t5_valid", 32'(ResultValid), 32'h1);
        check("t5_rates", 32'(Rates), 32'h00FF);
        check("t5_sat",   32'(Saturated), 32'h1);
        ack_cycle();

        // ---- GateLen=0 uses the default gate ----
        GateLen = 16'd0; Continuous = 0; Start = 1;
        step();
        Start = 0;
        for (int e = 1; e <= 66; e++) begin
            step();
            if (e == 65) check("t6_valid_early", 32'(ResultValid), 32'h0);
        end
        check("t6_valid", 32'(ResultValid), 32'h1);
        check("t6_wc",    32'(WindowCount), 32'd9);
        ack_cycle();
        // Reset in the middle of a counting window.
        Continuous = 1; Start = 1;
        step();
        Start = 0;
        for (int e = 1; e <= 30; e++) begin
            PulseIn = 4'($urandom);
            step();
        end
        PulseIn = '0;
        mid_reset();
        GateLen = 16'd3; Continuous = 0; Start = 1; PulseIn = 4'b0100;
        step();
        Start = 0; PulseIn = '0;
        for (int e = 1; e <= 5; e++) begin
            step();
            if (e == 4) check("t6_post_rst_early", 32'(ResultValid), 32'h0);
        end
        check("t6_post_rst_valid", 32'(ResultValid), 32'h1);
        check("t6_post_rst_rates", 32'(Rates), 32'h0100);
        check("t6_post_rst_wc",    32'(WindowCount), 32'd1);
        ack_cycle();

        // ---- table-driven vectors ----
        for (int i = 0; i < 14; i++) begin
            Start = tbl[i].start; Stop = tbl[i].stop; Continuous = tbl[i].cont;
            GateLen = tbl[i].glen; PulseIn = tbl[i].pulse; ResultAck = tbl[i].ack;
            step();
            check($sformatf("tbl%0d_valid", i), 32'(ResultValid), 32'(tbl[i].exp_valid));
            check($sformatf("tbl%0d_busy", i),  32'(Busy),        32'(tbl[i].exp_busy));
            check($sformatf("tbl%0d_rates", i), 32'(Rates),       32'(tbl[i].exp_rates));
            check($sformatf("tbl%0d_wc", i),    32'(WindowCount), 32'(tbl[i].exp_wc));
        end
        Start = 0; Stop = 0; ResultAck = 0; PulseIn = '0;

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 4000; i++) begin
            Start      = ($urandom_range(0, 9) == 0);
            Stop       = ($urandom_range(0, 99) == 0);
            Continuous = ($urandom_range(0, 1) == 1);
            GateLen    = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
            PulseIn    = 4'($urandom);
            ResultAck  = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
